// File: rtl/jtopl_pg_ring.sv
// -----------------------------------------------------------------------------
// jtopl_pg_ring
//
// Per-slot phase state store for the OPL phase generator. The 19-bit phase
// accumulators of all operator slots live in a rotating ring. The head of the
// ring is the current slot's stored phase. The phase-sum stage returns the
// updated phase in the same cycle, and that value is written back at the tail.
// A parallel 1-bit ring remembers the key-on state seen at each slot's last
// visit. From it the block produces a one-shot phase reset on a key-on rising
// edge. The upper 10 bits of the written phase are registered together with
// their slot tag for the operator pipeline.
//
// Optional feature macro: JTOPL_PG_FREEZE_EN (adds the pg_freeze input).
//
// Parameters:
//   SLOTS      number of operator slots in the ring (default 18)
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   cen        clock enable; the ring advances one slot per enabled edge
//   keyon      key-on state of the current slot
//   phase_in   stored phase of the current slot (ring head), combinational
//   pg_rst     phase reset request for the current slot, combinational
//   phase_out  updated phase for the current slot, from the phase-sum stage
//   slot       current slot index, 0..SLOTS-1
//   zero       high while slot == 0 (frame sync)
//   op_phase   registered write value [18:9] of the previous slot
//   op_slot    slot index matching op_phase
//   pg_freeze  (JTOPL_PG_FREEZE_EN only) hold stored phases unless pg_rst
// -----------------------------------------------------------------------------
module jtopl_pg_ring #(
  parameter int SLOTS = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        keyon,
  output logic [18:0] phase_in,
  output logic        pg_rst,
  input  logic [18:0] phase_out,
  output logic [4:0]  slot,
  output logic        zero,
  output logic [9:0]  op_phase,
  output logic [4:0]  op_slot
`ifdef JTOPL_PG_FREEZE_EN
  ,
  input  logic        pg_freeze
`endif
);

  localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);

  logic [18:0]      ring [SLOTS];
  logic [SLOTS-1:0] kon_hist;
  logic             kon_head;
  logic [18:0]      wr_val;

  assign phase_in = ring[0];
  assign kon_head = kon_hist[0];

  // A slot requests a phase reset only when it is keyed on now but was not
  // keyed on at its previous visit.
  assign pg_rst = keyon & ~kon_head;

  assign zero = (slot == 5'd0);

  // Freeze recirculates the stored phase, but a pending phase reset still
  // wins so that key-on always restarts the operator from phase 0.
`ifdef JTOPL_PG_FREEZE_EN
  assign wr_val = (pg_freeze && !pg_rst) ? phase_in : phase_out;
`else
  assign wr_val = phase_out;
`endif

  // Ring rotation: the head moves one step toward index 0 and the tail takes
  // the written value. This means each value returns to the head SLOTS enabled
  // edges later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        ring[i] <= '0;
      end
      kon_hist <= '0;
      slot     <= '0;
      op_phase <= '0;
      op_slot  <= '0;
    end else if (cen) begin
      for (int i = 0; i < SLOTS - 1; i++) begin
        ring[i] <= ring[i+1];
      end
      ring[SLOTS-1] <= wr_val;
      kon_hist      <= {keyon, kon_hist[SLOTS-1:1]};
      slot          <= (slot == LAST_SLOT) ? 5'd0 : slot + 5'd1;
      op_phase      <= wr_val[18:9];
      op_slot       <= slot;
    end
  end

endmodule

// File: tb/tb_jtopl_pg_ring.sv
// -----------------------------------------------------------------------------
// tb_jtopl_pg_ring
//
// Directed testbench for jtopl_pg_ring. The bench plays the phase-sum stage.
// It returns 0 while pg_rst is high and otherwise returns phase_in + add_val,
// wrapped to 19 bits. Expected values are hand-computed from that behaviour.
// -----------------------------------------------------------------------------
module tb_jtopl_pg_ring;

  localparam int SLOTS = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b0;
  logic        keyon = 1'b0;
  logic [18:0] phase_in;
  logic        pg_rst;
  logic [18:0] phase_out;
  logic [4:0]  slot;
  logic        zero;
  logic [9:0]  op_phase;
  logic [4:0]  op_slot;
`ifdef JTOPL_PG_FREEZE_EN
  logic        pg_freeze = 1'b0;
`endif

  logic [18:0] add_val = 19'h0;
  int n_cmp = 0;
  int n_bad = 0;

  jtopl_pg_ring #(.SLOTS(SLOTS)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .keyon     (keyon),
    .phase_in  (phase_in),
    .pg_rst    (pg_rst),
    .phase_out (phase_out),
    .slot      (slot),
    .zero      (zero),
    .op_phase  (op_phase),
    .op_slot   (op_slot)
`ifdef JTOPL_PG_FREEZE_EN
    ,
    .pg_freeze (pg_freeze)
`endif
  );

  always #5 clk = ~clk;

  // Phase-sum stage model: adds modulo 2^19 and clears on a phase reset.
  always_comb begin
    phase_out = pg_rst ? 19'h0 : 19'(phase_in + add_val);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    cen = 1'b0;
    keyon = 1'b0;
    do_reset();
    rst = 1'b1;
    #1;
    n_cmp++; if (slot !== 5'd0) begin n_bad++; $display("[TB] FAIL reset_slot got %0d want 0", slot); end
    n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_zero got %b want 1", zero); end
    n_cmp++; if (phase_in !== 19'h0) begin n_bad++; $display("[TB] FAIL reset_phase got %h want 0", phase_in); end
    n_cmp++; if (op_phase !== 10'h0) begin n_bad++; $display("[TB] FAIL reset_op_phase got %h want 0", op_phase); end
    n_cmp++; if (op_slot !== 5'd0) begin n_bad++; $display("[TB] FAIL reset_op_slot got %0d want 0", op_slot); end
    n_cmp++; if (pg_rst !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_pg_rst_lo got %b want 0", pg_rst); end
    keyon = 1'b1;
    #1;
    n_cmp++; if (pg_rst !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_pg_rst_hi got %b want 1", pg_rst); end
    keyon = 1'b0;
    rst = 1'b0;
    #1;
  endtask

  // Two full rotations adding 0x80: the first reads all zeros, the second 0x80.
  task automatic test_rotation();
    do_reset();
    add_val = 19'h80;
    cen = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < SLOTS; i++) begin
        n_cmp++; if (slot !== 5'(i)) begin n_bad++; $display("[TB] FAIL rot_slot r%0d got %0d want %0d", r, slot, i); end
        n_cmp++; if (zero !== (i == 0)) begin n_bad++; $display("[TB] FAIL rot_zero r%0d s%0d got %b want %b", r, i, zero, (i == 0)); end
        n_cmp++; if (phase_in !== (r == 0 ? 19'h0 : 19'h80)) begin n_bad++; $display("[TB] FAIL rot_phase r%0d s%0d got %h want %h", r, i, phase_in, (r == 0 ? 19'h0 : 19'h80)); end
        tick();
        n_cmp++; if (op_slot !== 5'(i)) begin n_bad++; $display("[TB] FAIL rot_op_slot got %0d want %0d", op_slot, i); end
        n_cmp++; if (op_phase !== 10'h0) begin n_bad++; $display("[TB] FAIL rot_op_phase got %h want 0", op_phase); end
      end
    end
    n_cmp++; if (slot !== 5'd0 || zero !== 1'b1) begin n_bad++; $display("[TB] FAIL rot_wrap got slot %0d zero %b want 0/1", slot, zero); end
    cen = 1'b0;
  endtask

  // Adding 2^18 twice wraps back to zero; the top bits show up on op_phase.
  task automatic test_wrap();
    logic [18:0] exp_ph [3];
    logic [9:0]  exp_op [3];
    exp_ph[0] = 19'h0;  exp_ph[1] = 19'h40000; exp_ph[2] = 19'h0;
    exp_op[0] = 10'h200; exp_op[1] = 10'h000;  exp_op[2] = 10'h200;
    do_reset();
    add_val = 19'h40000;
    cen = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (i == 3) begin
          n_cmp++; if (phase_in !== exp_ph[r]) begin n_bad++; $display("[TB] FAIL wrap_phase r%0d got %h want %h", r, phase_in, exp_ph[r]); end
        end
        tick();
        if (i == 3 && r < 2) begin
          n_cmp++; if (op_phase !== exp_op[r]) begin n_bad++; $display("[TB] FAIL wrap_op_phase r%0d got %h want %h", r, op_phase, exp_op[r]); end
        end
      end
    end
    cen = 1'b0;
  endtask

  // Key-on held on slot 5, dropped in rotation 3 and reasserted in rotation 4.
  task automatic test_keyon();
    logic        exp_rst [6];
    logic [18:0] exp_ph  [6];
    exp_rst[0] = 1'b1; exp_rst[1] = 1'b0; exp_rst[2] = 1'b0;
    exp_rst[3] = 1'b0; exp_rst[4] = 1'b1; exp_rst[5] = 1'b0;
    exp_ph[0] = 19'h0;   exp_ph[1] = 19'h0;   exp_ph[2] = 19'h100;
    exp_ph[3] = 19'h200; exp_ph[4] = 19'h300; exp_ph[5] = 19'h0;
    do_reset();
    add_val = 19'h100;
    cen = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < SLOTS; i++) begin
        keyon = (i == 5) && (r != 3);
        #1;
        if (i == 5) begin
          n_cmp++; if (pg_rst !== exp_rst[r]) begin n_bad++; $display("[TB] FAIL kon_pg_rst r%0d got %b want %b", r, pg_rst, exp_rst[r]); end
          n_cmp++; if (phase_in !== exp_ph[r]) begin n_bad++; $display("[TB] FAIL kon_phase r%0d got %h want %h", r, phase_in, exp_ph[r]); end
        end
        if (i == 6 && r == 0) begin
          n_cmp++; if (pg_rst !== 1'b0) begin n_bad++; $display("[TB] FAIL kon_other got %b want 0", pg_rst); end
        end
        tick();
      end
    end
    keyon = 1'b0;
    cen = 1'b0;
  endtask

  // cen pulses once every third clock; everything holds in between.
  task automatic test_cen();
    do_reset();
    add_val = 19'h12345;
    cen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      n_cmp++; if (slot !== 5'(k)) begin n_bad++; $display("[TB] FAIL cen_hold_slot got %0d want %0d", slot, k); end
      n_cmp++; if (phase_in !== 19'h0) begin n_bad++; $display("[TB] FAIL cen_hold_phase got %h want 0", phase_in); end
      if (k > 0) begin
        n_cmp++; if (op_slot !== 5'(k - 1) || op_phase !== 10'h091) begin n_bad++; $display("[TB] FAIL cen_hold_op got %0d/%h want %0d/091", op_slot, op_phase, k - 1); end
      end
      cen = 1'b1;
      tick();
      cen = 1'b0;
      n_cmp++; if (slot !== 5'(k + 1)) begin n_bad++; $display("[TB] FAIL cen_step_slot got %0d want %0d", slot, k + 1); end
      n_cmp++; if (op_phase !== 10'h091) begin n_bad++; $display("[TB] FAIL cen_step_op got %h want 091", op_phase); end
    end
  endtask

  // Reset dropped in at slot 9 of the second rotation, between clock edges.
  task automatic test_async_reset();
    do_reset();
    add_val = 19'h12345;
    cen = 1'b1;
    for (int i = 0; i < SLOTS + 9; i++) tick();
    n_cmp++; if (slot !== 5'd9 || phase_in !== 19'h12345) begin n_bad++; $display("[TB] FAIL ares_pre got %0d/%h want 9/12345", slot, phase_in); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (slot !== 5'd0 || zero !== 1'b1) begin n_bad++; $display("[TB] FAIL ares_slot got %0d/%b want 0/1", slot, zero); end
    n_cmp++; if (phase_in !== 19'h0 || op_phase !== 10'h0 || op_slot !== 5'd0) begin n_bad++; $display("[TB] FAIL ares_state got %h/%h/%0d want 0/0/0", phase_in, op_phase, op_slot); end
    rst = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      n_cmp++; if (slot !== 5'(i) || phase_in !== 19'h0) begin n_bad++; $display("[TB] FAIL ares_rot got %0d/%h want %0d/0", slot, phase_in, i); end
      tick();
    end
    n_cmp++; if (phase_in !== 19'h12345) begin n_bad++; $display("[TB] FAIL ares_after got %h want 12345", phase_in); end
    cen = 1'b0;
  endtask

`ifdef JTOPL_PG_FREEZE_EN
  // Freeze one rotation; the key-on at slot 2 still clears its phase.
  task automatic test_freeze();
    do_reset();
    add_val = 19'h1;
    cen = 1'b1;
    for (int i = 0; i < SLOTS; i++) tick();
    pg_freeze = 1'b1;
    for (int i = 0; i < SLOTS; i++) begin
      keyon = (i == 2);
      #1;
      if (i == 1) begin
        n_cmp++; if (phase_in !== 19'h1) begin n_bad++; $display("[TB] FAIL frz_phase got %h want 1", phase_in); end
      end
      if (i == 2) begin
        n_cmp++; if (pg_rst !== 1'b1) begin n_bad++; $display("[TB] FAIL frz_pg_rst got %b want 1", pg_rst); end
      end
      tick();
    end
    pg_freeze = 1'b0;
    keyon = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      #1;
      if (i == 0 || i == 4) begin
        n_cmp++; if (phase_in !== 19'h1) begin n_bad++; $display("[TB] FAIL frz_keep s%0d got %h want 1", i, phase_in); end
      end
      if (i == 2) begin
        n_cmp++; if (phase_in !== 19'h0) begin n_bad++; $display("[TB] FAIL frz_clear got %h want 0", phase_in); end
      end
      tick();
    end
    cen = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_rotation();
    test_wrap();
    test_keyon();
    test_cen();
    test_async_reset();
`ifdef JTOPL_PG_FREEZE_EN
    test_freeze();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
